// File: rtl/i8051_pkg.sv
// Shared 8051 definitions: default code address width, opcode constants and the
// instruction length decode used by both the prefetch queue and core decode.
package i8051_pkg;

    localparam int ADDR_W_DFLT = 16;

    localparam logic [7:0] NOP         = 8'h00;
    localparam logic [7:0] INC_RN      = 8'h08;
    localparam logic [7:0] DEC_RN      = 8'h18;
    localparam logic [7:0] MOV_RN_IMM  = 8'h78;
    localparam logic [7:0] CJNE_RN_IMM = 8'hB8;

    // Register-bank opcode groups span eight codes, so only the top five bits decide length.
    function automatic logic [1:0] instr_len(input logic [7:0] opcode);
        logic [1:0] len;
        unique case (opcode[7:3])
            MOV_RN_IMM[7:3]:                      len = 2'd2;
            CJNE_RN_IMM[7:3]:                     len = 2'd3;
            NOP[7:3], INC_RN[7:3], DEC_RN[7:3]:   len = 2'd1;
            default:                              len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/i8051_byte_fifo.sv
// DEPTH-entry byte FIFO with a 1-3 byte pop, a three-entry head peek and a
// synchronous flush that takes priority over push and pop.
module i8051_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic [1:0]               pop_len,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               peek0,
    output logic [7:0]               peek1,
    output logic [7:0]               peek2
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr1;
    logic [PTR_W-1:0] rd_ptr2;
    logic [PTR_W:0]   pop_cnt;

    assign pop_cnt = pop ? (PTR_W+1)'(pop_len) : '0;
    assign rd_ptr1 = rd_ptr + PTR_W'(1);
    assign rd_ptr2 = rd_ptr + PTR_W'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(pop_len);
            count <= count + (PTR_W+1)'(push) - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign peek0 = mem[rd_ptr];
    assign peek1 = mem[rd_ptr1];
    assign peek2 = mem[rd_ptr2];

endmodule

// File: rtl/i8051_prefetch_queue.sv
// 8051 instruction prefetch: streams code bytes into a byte FIFO and presents whole
// instructions to the core. Define I8051_PF_STATS_EN for stat_instr/stat_flush counters.
//
// state | meaning
// RUN   | normal fetch; each return is pushed into the queue
// KILL  | cycle after a redirect; drops the in-flight return, fetches at redirect_pc
module i8051_prefetch_queue
    import i8051_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_op1,
    output logic [7:0]        instr_op2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc
`ifdef I8051_PF_STATS_EN
    ,
    output logic [15:0]       stat_instr,
    output logic [15:0]       stat_flush
`endif
);

    localparam int   CNT_W   = $clog2(DEPTH) + 1;
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_KILL = 1'b1;

    logic              state;
    logic              inflight;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] head_pc;
    logic [CNT_W-1:0]  count;
    logic [7:0]        peek0;
    logic [7:0]        peek1;
    logic [7:0]        peek2;
    logic [1:0]        head_len;
    logic              has_room;
    logic              push;
    logic              pop;
    logic [7:0]        hold_opcode;
    logic [7:0]        hold_op1;
    logic [7:0]        hold_op2;
    logic [1:0]        hold_len;
    logic [ADDR_W-1:0] hold_pc;

    i8051_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (imem_rdata),
        .pop       (pop),
        .pop_len   (head_len),
        .count     (count),
        .peek0     (peek0),
        .peek1     (peek1),
        .peek2     (peek2)
    );

    // Outstanding reads reserve a slot so a return can never find the queue full.
    assign has_room    = ({1'b0, count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH);
    assign imem_rd     = rst_n && (state == ST_KILL || has_room);
    assign imem_addr   = fpc;
    assign push        = inflight && (state == ST_RUN);
    assign head_len    = i8051_pkg::instr_len(peek0);
    assign instr_valid = count >= CNT_W'(head_len);
    assign pop         = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            inflight <= 1'b0;
            fpc      <= '0;
            head_pc  <= '0;
        end else begin
            inflight <= imem_rd;
            if (redirect) begin
                state   <= ST_KILL;
                fpc     <= redirect_pc;
                head_pc <= redirect_pc;
            end else begin
                state <= ST_RUN;
                if (imem_rd)
                    fpc <= fpc + ADDR_W'(1);
                if (pop)
                    head_pc <= head_pc + ADDR_W'(head_len);
            end
        end
    end

    // An empty queue shows the last presented instruction; operand bytes not yet
    // arrived or beyond the instruction length read as 00.
    always_comb begin
        instr_opcode = hold_opcode;
        instr_op1    = hold_op1;
        instr_op2    = hold_op2;
        instr_len    = hold_len;
        instr_pc     = hold_pc;
        if (count != '0) begin
            instr_opcode = peek0;
            instr_len    = head_len;
            instr_op1    = (head_len >= 2'd2 && count >= CNT_W'(2)) ? peek1 : 8'h00;
            instr_op2    = (head_len == 2'd3 && count >= CNT_W'(3)) ? peek2 : 8'h00;
            instr_pc     = head_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_opcode <= 8'h00;
            hold_op1    <= 8'h00;
            hold_op2    <= 8'h00;
            hold_len    <= 2'd1;
            hold_pc     <= '0;
        end else begin
            hold_opcode <= instr_opcode;
            hold_op1    <= instr_op1;
            hold_op2    <= instr_op2;
            hold_len    <= instr_len;
            hold_pc     <= instr_pc;
        end
    end

`ifdef I8051_PF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_instr <= '0;
            stat_flush <= '0;
        end else begin
            if (pop && stat_instr != 16'hFFFF)
                stat_instr <= stat_instr + 16'd1;
            if (redirect && stat_flush != 16'hFFFF)
                stat_flush <= stat_flush + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i8051_prefetch_queue.sv
// Self-checking bench for i8051_prefetch_queue: synchronous code memory model and an
// instruction scoreboard filled from the memory image whenever a fetch stream is started.
module tb_i8051_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [7:0]  imem_rdata = 8'h00;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_op1;
    logic [7:0]  instr_op2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
`ifdef I8051_PF_STATS_EN
    logic [15:0] stat_instr;
    logic [15:0] stat_flush;
`endif

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [65536];
    int         n_checks = 0;
    int         n_errors = 0;
    int         remaining = 0;

    i8051_prefetch_queue #(.DEPTH(4), .ADDR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_rd      (imem_rd),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_len    (instr_len),
        .instr_pc     (instr_pc)
`ifdef I8051_PF_STATS_EN
        ,
        .stat_instr   (stat_instr),
        .stat_flush   (stat_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd)
            imem_rdata <= mem[imem_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        if (op >= 8'h78 && op <= 8'h7F)
            return 2'd2;
        else if (op >= 8'hB8 && op <= 8'hBF)
            return 2'd3;
        return 2'd1;
    endfunction

    task automatic expect_stream(input logic [15:0] addr, input int n);
        exp_t        e;
        logic [15:0] a;
        logic [15:0] a1;
        logic [15:0] a2;
        a = addr;
        for (int i = 0; i < n; i++) begin
            a1       = a + 16'd1;
            a2       = a + 16'd2;
            e.opcode = mem[a];
            e.len    = ref_len(e.opcode);
            e.op1    = (e.len >= 2'd2) ? mem[a1] : 8'h00;
            e.op2    = (e.len == 2'd3) ? mem[a2] : 8'h00;
            e.pc     = a;
            exp_q.push_back(e);
            a = a + 16'(e.len);
        end
        remaining = remaining + n;
    endtask

    // Scores a transfer happening at the coming edge, then advances to the next negedge.
    task automatic step();
        exp_t e;
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check_val("sb_avail", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_opcode", 32'(instr_opcode), 32'(e.opcode));
                check_val("sb_op1",    32'(instr_op1),    32'(e.op1));
                check_val("sb_op2",    32'(instr_op2),    32'(e.op2));
                check_val("sb_len",    32'(instr_len),    32'(e.len));
                check_val("sb_pc",     32'(instr_pc),     32'(e.pc));
                if (remaining > 0)
                    remaining--;
            end
        end
        @(negedge clk);
        if (remaining == 0)
            instr_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (remaining != 0 && n < 40) begin
            step();
            n++;
        end
        check_val(tag, 32'(remaining), 32'd0);
        check_val({tag, "_q"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rd"},     32'(imem_rd),      32'd0);
        check_val({tag, "_addr"},   32'(imem_addr),    32'd0);
        check_val({tag, "_valid"},  32'(instr_valid),  32'd0);
        check_val({tag, "_opcode"}, 32'(instr_opcode), 32'd0);
        check_val({tag, "_op1"},    32'(instr_op1),    32'd0);
        check_val({tag, "_op2"},    32'(instr_op2),    32'd0);
        check_val({tag, "_len"},    32'(instr_len),    32'd1);
        check_val({tag, "_pc"},     32'(instr_pc),     32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        instr_ready = 1'b0;
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'h00;
        mem[16'h0008] = 8'hB9;
        mem[16'h0009] = 8'h00;
        mem[16'h000A] = 8'hFC;
        mem[16'h000C] = 8'h3C;
        mem[16'h0020] = 8'h78;
        mem[16'h0021] = 8'h02;
        mem[16'h0022] = 8'h79;
        mem[16'h0023] = 8'h02;
        mem[16'h0024] = 8'h7A;
        mem[16'h0025] = 8'h00;
        mem[16'h1234] = 8'h3C;
        mem[16'hFFFF] = 8'h79;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Release: issue 0000/0001/0002 on consecutive cycles, NOP valid in cycle 2.
        rst_n = 1'b1;
        #1;
        check_val("c0_rd",   32'(imem_rd),   32'd1);
        check_val("c0_addr", 32'(imem_addr), 32'h0000);
        step();
        check_val("c1_addr",  32'(imem_addr),   32'h0001);
        check_val("c1_valid", 32'(instr_valid), 32'd0);
        step();
        check_val("c2_addr",   32'(imem_addr),    32'h0002);
        check_val("c2_valid",  32'(instr_valid),  32'd1);
        check_val("c2_opcode", 32'(instr_opcode), 32'h00);
        check_val("c2_len",    32'(instr_len),    32'd1);
        check_val("c2_pc",     32'(instr_pc),     32'h0000);
        step();
        check_val("c3_addr", 32'(imem_addr), 32'h0003);

        // Two-byte MOV stream with ready held high.
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        expect_stream(16'h0020, 3);
        instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        drain("t2_done");

        // CJNE at 0008 with ready low: fetch stalls once four bytes are owned.
        redirect    = 1'b1;
        redirect_pc = 16'h0008;
        step();
        redirect = 1'b0;
        step();
        step();
        step();
        check_val("t3_valid_r4", 32'(instr_valid), 32'd0);
        step();
        check_val("t3_valid_r5", 32'(instr_valid), 32'd1);
        step();
        step();
        step();
        check_val("t3_stall_rd",   32'(imem_rd),      32'd0);
        check_val("t3_stall_addr", 32'(imem_addr),    32'h000C);
        check_val("t3_opcode",     32'(instr_opcode), 32'hB9);
        check_val("t3_len",        32'(instr_len),    32'd3);
        check_val("t3_op1",        32'(instr_op1),    32'h00);
        check_val("t3_op2",        32'(instr_op2),    32'hFC);
        step();
        check_val("t3_stall_rd2", 32'(imem_rd), 32'd0);
        expect_stream(16'h0008, 1);
        instr_ready = 1'b1;
        step();
        check_val("t3_post_valid", 32'(instr_valid), 32'd1);
        check_val("t3_post_pc",    32'(instr_pc),    32'h000B);
        check_val("t3_post_rd",    32'(imem_rd),     32'd1);

        // Redirect with a read in flight: that return must be dropped.
        check_val("t4_pre_rd", 32'(imem_rd), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0006;
        expect_stream(16'h0006, 3);
        instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        check_val("t4_r1_rd",   32'(imem_rd),   32'd1);
        check_val("t4_r1_addr", 32'(imem_addr), 32'h0006);
        step();
        check_val("t4_r2_valid", 32'(instr_valid), 32'd0);
        step();
        check_val("t4_r3_valid", 32'(instr_valid), 32'd1);
        check_val("t4_r3_pc",    32'(instr_pc),    32'h0006);
        drain("t4_done");

        // Redirect during KILL to FFFF; fetch wraps to 0000.
        mem[16'h0000] = 8'h05;
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        step();
        redirect_pc = 16'hFFFF;
        expect_stream(16'hFFFF, 1);
        instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        check_val("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
        check_val("t5_rd_ffff",   32'(imem_rd),   32'd1);
        step();
        check_val("t5_addr_wrap", 32'(imem_addr), 32'h0000);
        drain("t5_done");
        check_val("t5_pc_wrap", 32'(instr_pc), 32'h0001);

        // Reset mid-stream.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("t6_rd",   32'(imem_rd),   32'd1);
        check_val("t6_addr", 32'(imem_addr), 32'h0000);
        expect_stream(16'h0000, 2);
        instr_ready = 1'b1;
        drain("t6_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
